// File: rtl/me_search_ctrl_if.sv
// Purpose: bundles the search-controller bus: start/busy/done, memory addresses, PE controls, distortions and results.
// Ports: master = controller side (drives addresses, PE controls, results); slave = memories/PE array/host side.
// Parameters N (block size, power of two) and DW (pixel/distortion width) must match the controller instance.
interface me_search_ctrl_if #(
    parameter int N  = 16,
    parameter int DW = 8
);
    localparam int LOGN = $clog2(N);

    logic                start;
    logic                busy;
    logic                done;
    logic [2*LOGN-1:0]   r_addr;
    logic                r_en;
    logic [2*LOGN:0]     s1_addr;
    logic [2*LOGN:0]     s2_addr;
    logic                s_en;
    logic [N-1:0]        s1s2_mux;
    logic [N-1:0]        new_dist;
    logic [N*DW-1:0]     acc_bus;
    logic [DW-1:0]       best_dist;
    logic [LOGN-1:0]     best_mv_x;
    logic [LOGN-1:0]     best_mv_y;

    modport master (
        input  start, acc_bus,
        output busy, done, r_addr, r_en, s1_addr, s2_addr, s_en,
               s1s2_mux, new_dist, best_dist, best_mv_x, best_mv_y
    );

    modport slave (
        output start, acc_bus,
        input  busy, done, r_addr, r_en, s1_addr, s2_addr, s_en,
               s1s2_mux, new_dist, best_dist, best_mv_x, best_mv_y
    );
endinterface

// File: rtl/me_search_ctrl.sv
// Purpose: full-search SAD sequencer for an N-PE block-matching array; drives memory addresses and PE controls, tracks minimum-SAD vector.
// Latency: N passes of N*N+N+1 cycles, done pulses in cycle N*(N*N+N+1)+1 after start is sampled; start ignored while busy.
// Ports: clock, reset_n (async active-low), bus (me_search_ctrl_if.master). Optional macro ME_EARLY_EXIT_EN: stop after a pass once best_dist is 0.
module me_search_ctrl #(
    parameter int N  = 16,
    parameter int DW = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    me_search_ctrl_if.master   bus
);
    localparam int LOGN = $clog2(N);
    localparam int NPE  = N;
    // pc spans 0..N*N+N, which always fits in 2*LOGN+1 bits
    localparam int PCW  = 2 * LOGN + 1;

    localparam logic [PCW-1:0]  PC_LAST      = PCW'(N * N + NPE);
    localparam logic [PCW-1:0]  PC_ISSUE_END = PCW'(N * N + NPE - 2);
    localparam logic [PCW-1:0]  PC_REF_END   = PCW'(N * N);
    localparam logic [PCW-1:0]  PC_SAMP0     = PCW'(N * N + 1);
    localparam logic [LOGN-1:0] V_LAST       = LOGN'(N - 1);
    localparam logic [LOGN-1:0] HALF         = LOGN'(N / 2);
    localparam logic [LOGN-1:0] K_ONE        = LOGN'(1);
    localparam logic [LOGN:0]   ROW_ONE      = (LOGN + 1)'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PASS = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [PCW-1:0]    pc_q, pc_d;
    logic [LOGN-1:0]   v_q, v_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [2*LOGN-1:0] r_addr_q, r_addr_d;
    logic              r_en_q, r_en_d;
    logic [2*LOGN:0]   s1_addr_q, s1_addr_d;
    logic [2*LOGN:0]   s2_addr_q, s2_addr_d;
    logic              s_en_q, s_en_d;
    logic [NPE-1:0]    s1s2_mux_q, s1s2_mux_d;
    logic [NPE-1:0]    new_dist_q, new_dist_d;
    logic [DW-1:0]     best_dist_q, best_dist_d;
    logic [LOGN-1:0]   best_mv_x_q, best_mv_x_d;
    logic [LOGN-1:0]   best_mv_y_q, best_mv_y_d;

    logic              sampling;
    logic [LOGN-1:0]   samp_k;
    logic [DW-1:0]     cand;
    logic              early_exit;
    logic              in_win_q;
    logic              in_win_d;
    logic [LOGN:0]     row_d;

    always_comb begin
        // ---------------- best-match tracking ----------------
        best_dist_d = best_dist_q;
        best_mv_x_d = best_mv_x_q;
        best_mv_y_d = best_mv_y_q;
        sampling    = (state_q == ST_PASS) && (pc_q >= PC_SAMP0);
        // PE k is sampled at pc = N*N+1+k; since N*N+1 = 1 mod N, k = pc[LOGN-1:0] - 1
        samp_k      = pc_q[LOGN-1:0] - K_ONE;
        cand        = '0;
        for (int k = 0; k < NPE; k++) begin
            if (samp_k == LOGN'(k)) begin
                cand = bus.acc_bus[k*DW +: DW];
            end
        end
        if (sampling) begin
            // first candidate loads unconditionally; strict < keeps the earliest on ties
            if (((v_q == '0) && (samp_k == '0)) || (cand < best_dist_q)) begin
                best_dist_d = cand;
                best_mv_x_d = samp_k - HALF;
                best_mv_y_d = v_q - HALF;
            end
        end

`ifdef ME_EARLY_EXIT_EN
        early_exit = (best_dist_d == '0);
`else
        early_exit = 1'b0;
`endif

        // ---------------- sequencing ----------------
        state_d = state_q;
        pc_d    = pc_q;
        v_d     = v_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_PASS;
                    pc_d    = '0;
                    v_d     = '0;
                end
            end
            ST_PASS: begin
                if (pc_q == PC_LAST) begin
                    pc_d = '0;
                    if ((v_q == V_LAST) || early_exit) begin
                        state_d = ST_DONE;
                    end else begin
                        v_d = v_q + K_ONE;
                    end
                end else begin
                    pc_d = pc_q + PCW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);

        // ---------------- memory addressing (valid in the cycle pc = c) ----------------
        in_win_d  = (state_d == ST_PASS) && (pc_d <= PC_ISSUE_END);
        row_d     = pc_d[2*LOGN:LOGN] + {1'b0, v_d};
        s_en_d    = in_win_d;
        s1_addr_d = s1_addr_q;
        s2_addr_d = s2_addr_q;
        if (in_win_d) begin
            s1_addr_d = {row_d, pc_d[LOGN-1:0]};
            // wraps for c < N on the first pass; the PE never selects that data
            s2_addr_d = {row_d - ROW_ONE, pc_d[LOGN-1:0]};
        end
        r_en_d   = (state_d == ST_PASS) && (pc_d < PC_REF_END);
        r_addr_d = r_en_d ? pc_d[2*LOGN-1:0] : r_addr_q;

        // ---------------- PE controls: one-cycle-delayed decode of c ----------------
        in_win_q   = (state_q == ST_PASS) && (pc_q <= PC_ISSUE_END);
        new_dist_d = '0;
        s1s2_mux_d = '0;
        if (in_win_q) begin
            for (int k = 0; k < NPE; k++) begin
                new_dist_d[k] = (pc_q == PCW'(k));
                s1s2_mux_d[k] = (pc_q[LOGN-1:0] >= LOGN'(k));
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            v_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            r_addr_q    <= '0;
            r_en_q      <= 1'b0;
            s1_addr_q   <= '0;
            s2_addr_q   <= '0;
            s_en_q      <= 1'b0;
            s1s2_mux_q  <= '0;
            new_dist_q  <= '0;
            best_dist_q <= '1;
            best_mv_x_q <= '0;
            best_mv_y_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            v_q         <= v_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            r_addr_q    <= r_addr_d;
            r_en_q      <= r_en_d;
            s1_addr_q   <= s1_addr_d;
            s2_addr_q   <= s2_addr_d;
            s_en_q      <= s_en_d;
            s1s2_mux_q  <= s1s2_mux_d;
            new_dist_q  <= new_dist_d;
            best_dist_q <= best_dist_d;
            best_mv_x_q <= best_mv_x_d;
            best_mv_y_q <= best_mv_y_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.r_addr    = r_addr_q;
    assign bus.r_en      = r_en_q;
    assign bus.s1_addr   = s1_addr_q;
    assign bus.s2_addr   = s2_addr_q;
    assign bus.s_en      = s_en_q;
    assign bus.s1s2_mux  = s1s2_mux_q;
    assign bus.new_dist  = new_dist_q;
    assign bus.best_dist = best_dist_q;
    assign bus.best_mv_x = best_mv_x_q;
    assign bus.best_mv_y = best_mv_y_q;
endmodule

// File: tb/tb_me_search_ctrl.sv
// Purpose: directed self-checking bench for me_search_ctrl (N=16, DW=8); PE distortions are supplied per pass from tables.
// Latency: each full search expects done in cycle 4369 after start (fewer with ME_EARLY_EXIT_EN on zero-SAD scenarios).
// Backpressure: none; start pulses during busy are expected to be ignored.
module tb_me_search_ctrl;
    localparam int N        = 16;
    localparam int DW       = 8;
    localparam int PLEN     = 273;
    localparam int FULL_LAT = 4369;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   e        = 0;   // cycles since the start-sampling edge (pc = e mod 273 during the search)
    int   cur_sc   = 0;

    me_search_ctrl_if #(.N(N), .DW(DW)) bus_if ();

    me_search_ctrl #(.N(N), .DW(DW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_if.master)
    );

    always #5 clock = ~clock;

    // SAD that PE k reports in pass v for each scenario
    function automatic logic [7:0] sad_f(int sc, int v, int k);
        case (sc)
            0: return (v == 8 && k == 8)  ? 8'd0 : 8'(1 + (v * 37 + k * 11) % 200);
            1: return (v == 6 && k == 11) ? 8'd0 : 8'(1 + (v * 53 + k * 29) % 230);
            2: return 8'd0;
            3: return 8'hFF;
            4: return ((v == 3 && (k == 5 || k == 9)) || (v == 10 && k == 2)) ? 8'd5
                      : 8'(20 + (v * 7 + k * 3) % 100);
            default: return 8'(255 - (v * 16 + k));
        endcase
    endfunction

    function automatic int exp_lat(int zp);
`ifdef ME_EARLY_EXIT_EN
        return (zp + 1) * PLEN + 1;
`else
        return FULL_LAT + 0 * zp;
`endif
    endfunction

    task automatic drive_acc();
        int p;
        p = e / PLEN;
        if (p > N - 1) p = N - 1;
        for (int k = 0; k < N; k++) bus_if.acc_bus[k*DW +: DW] = sad_f(cur_sc, p, k);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        e++;
        drive_acc();
    endtask

    task automatic launch(int sc);
        cur_sc = sc;
        e = 0;
        drive_acc();
        bus_if.start = 1'b1;
        @(posedge clock);
        #1;
        bus_if.start = 1'b0;
    endtask

    task automatic finish_search(string name, logic [7:0] xd, logic [3:0] xx, logic [3:0] xy,
                                 int zp, bit pulse);
        bit seen;
        seen = 1'b0;
        while (!seen && e < 6000) begin
            if (bus_if.done) seen = 1'b1;
            else begin
                bus_if.start = pulse && (e == 500 || e == 2000 || e == 4000);
                tick();
            end
        end
        bus_if.start = 1'b0;
        checks++;
        if (!seen || (e + 1) != exp_lat(zp)) begin
            failures++;
            $display("FAIL %s latency: got %0d (seen=%0b) expected %0d", name, e + 1, seen, exp_lat(zp));
        end
        checks++;
        if (bus_if.best_dist !== xd || bus_if.best_mv_x !== xx || bus_if.best_mv_y !== xy || bus_if.busy !== 1'b1) begin
            failures++;
            $display("FAIL %s result: got dist=%h x=%h y=%h busy=%b expected dist=%h x=%h y=%h busy=1",
                     name, bus_if.best_dist, bus_if.best_mv_x, bus_if.best_mv_y, bus_if.busy, xd, xx, xy);
        end
        tick();
        checks++;
        if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.best_dist !== xd || bus_if.best_mv_x !== xx) begin
            failures++;
            $display("FAIL %s after_done: got done=%b busy=%b dist=%h x=%h expected done=0 busy=0 dist=%h x=%h",
                     name, bus_if.done, bus_if.busy, bus_if.best_dist, bus_if.best_mv_x, xd, xx);
        end
    endtask

    task automatic check_reset_values(string name);
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 || bus_if.r_en !== 1'b0 || bus_if.s_en !== 1'b0 ||
            bus_if.r_addr !== 8'h00 || bus_if.s1_addr !== 9'h000 || bus_if.s2_addr !== 9'h000 ||
            bus_if.s1s2_mux !== 16'h0 || bus_if.new_dist !== 16'h0 || bus_if.best_dist !== 8'hFF ||
            bus_if.best_mv_x !== 4'h0 || bus_if.best_mv_y !== 4'h0) begin
            failures++;
            $display("FAIL %s: got busy=%b done=%b r_en=%b s_en=%b r_addr=%h s1=%h s2=%h mux=%h nd=%h dist=%h x=%h y=%h expected all zero, dist=ff",
                     name, bus_if.busy, bus_if.done, bus_if.r_en, bus_if.s_en, bus_if.r_addr, bus_if.s1_addr,
                     bus_if.s2_addr, bus_if.s1s2_mux, bus_if.new_dist, bus_if.best_dist, bus_if.best_mv_x, bus_if.best_mv_y);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus_if.start = 1'b0;
        bus_if.acc_bus = '0;
        repeat (2) @(posedge clock);
        #1;
        check_reset_values("reset_state");
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_control_timing();
        launch(0);
        for (int i = 0; i <= PLEN; i++) begin
            case (e)
                0: begin
                    checks++;
                    if (bus_if.busy !== 1'b1 || bus_if.done !== 1'b0 || bus_if.s1_addr !== 9'h000 ||
                        bus_if.s2_addr !== 9'h1F0 || bus_if.r_en !== 1'b1 || bus_if.s_en !== 1'b1 || bus_if.new_dist !== 16'h0) begin
                        failures++;
                        $display("FAIL pc0: got busy=%b done=%b s1=%h s2=%h r_en=%b s_en=%b nd=%h expected 1 0 000 1f0 1 1 0000",
                                 bus_if.busy, bus_if.done, bus_if.s1_addr, bus_if.s2_addr, bus_if.r_en, bus_if.s_en, bus_if.new_dist);
                    end
                end
                1: begin
                    checks++;
                    if (bus_if.new_dist !== 16'h0001 || bus_if.s1s2_mux !== 16'h0001) begin
                        failures++;
                        $display("FAIL pc1: got nd=%h mux=%h expected 0001 0001", bus_if.new_dist, bus_if.s1s2_mux);
                    end
                end
                4: begin
                    checks++;
                    if (bus_if.new_dist !== 16'h0008) begin
                        failures++;
                        $display("FAIL pc4_new_dist: got %h expected 0008", bus_if.new_dist);
                    end
                end
                17: begin
                    checks++;
                    if (bus_if.new_dist !== 16'h0000) begin
                        failures++;
                        $display("FAIL pc17_new_dist: got %h expected 0000", bus_if.new_dist);
                    end
                end
                20: begin
                    checks++;
                    if (bus_if.s1_addr !== 9'h014 || bus_if.s2_addr !== 9'h004) begin
                        failures++;
                        $display("FAIL c20_addr: got s1=%h s2=%h expected 014 004", bus_if.s1_addr, bus_if.s2_addr);
                    end
                end
                21: begin
                    checks++;
                    if (bus_if.s1s2_mux !== 16'h001F) begin
                        failures++;
                        $display("FAIL pc21_mux: got %h expected 001f", bus_if.s1s2_mux);
                    end
                end
                255: begin
                    checks++;
                    if (bus_if.r_en !== 1'b1 || bus_if.r_addr !== 8'hFF) begin
                        failures++;
                        $display("FAIL pc255_ref: got r_en=%b r_addr=%h expected 1 ff", bus_if.r_en, bus_if.r_addr);
                    end
                end
                256: begin
                    checks++;
                    if (bus_if.r_en !== 1'b0 || bus_if.r_addr !== 8'hFF) begin
                        failures++;
                        $display("FAIL pc256_ref: got r_en=%b r_addr=%h expected 0 ff", bus_if.r_en, bus_if.r_addr);
                    end
                end
                270: begin
                    checks++;
                    if (bus_if.s_en !== 1'b1 || bus_if.s1_addr !== 9'h10E) begin
                        failures++;
                        $display("FAIL pc270: got s_en=%b s1=%h expected 1 10e", bus_if.s_en, bus_if.s1_addr);
                    end
                end
                271: begin
                    checks++;
                    if (bus_if.s_en !== 1'b0 || bus_if.s1s2_mux !== 16'h7FFF) begin
                        failures++;
                        $display("FAIL pc271: got s_en=%b mux=%h expected 0 7fff", bus_if.s_en, bus_if.s1s2_mux);
                    end
                end
                272: begin
                    checks++;
                    if (bus_if.s1s2_mux !== 16'h0000 || bus_if.busy !== 1'b1) begin
                        failures++;
                        $display("FAIL pc272: got mux=%h busy=%b expected 0000 1", bus_if.s1s2_mux, bus_if.busy);
                    end
                end
                273: begin
                    checks++;
                    if (bus_if.s1_addr !== 9'h010 || bus_if.s2_addr !== 9'h000 || bus_if.r_addr !== 8'h00 || bus_if.r_en !== 1'b1) begin
                        failures++;
                        $display("FAIL pass1_pc0: got s1=%h s2=%h r_addr=%h r_en=%b expected 010 000 00 1",
                                 bus_if.s1_addr, bus_if.s2_addr, bus_if.r_addr, bus_if.r_en);
                    end
                end
                default: ;
            endcase
            tick();
        end
        finish_search("match_8_8", 8'h00, 4'h0, 4'h0, 8, 1'b0);
    endtask

    task automatic test_offsets();
        launch(1); finish_search("match_6_11", 8'h00, 4'h3, 4'hE, 6, 1'b0);
        launch(5); finish_search("last_best", 8'h00, 4'h7, 4'h7, 15, 1'b0);
    endtask

    task automatic test_ties();
        launch(2); finish_search("all_zero", 8'h00, 4'h8, 4'h8, 0, 1'b0);
        launch(3); finish_search("all_ff", 8'hFF, 4'h8, 4'h8, 15, 1'b0);
        launch(4); finish_search("tie_first", 8'h05, 4'hD, 4'hB, 15, 1'b0);
    endtask

    task automatic test_start_during_busy();
        launch(1);
        finish_search("start_busy", 8'h00, 4'h3, 4'hE, 6, 1'b1);
    endtask

    task automatic test_reset_mid_search();
        bit bad;
        launch(0);
        while (e < 5 * PLEN + 100) tick();
        reset_n = 1'b0;
        #1;
        check_reset_values("reset_mid");
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL reset_no_done: got activity after reset expected done=0 busy=0");
        end
        launch(1);
        finish_search("after_reset", 8'h00, 4'h3, 4'hE, 6, 1'b0);
    endtask

    initial begin
        bus_if.start = 1'b0;
        bus_if.acc_bus = '0;
        test_reset();
        test_control_timing();
        test_offsets();
        test_ties();
        test_start_during_busy();
        test_reset_mid_search();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/me_search_ctrl.md
Name: me_search_ctrl

Overview:
- Sequencer and best-match tracker for the linear array of NPE block-matching processing elements (full-search SAD motion estimation).
- Drives the reference and search-window memory addresses, the per-PE s1/s2 select and new_dist strobes, samples every PE's final distortion, and reports the minimum-SAD motion vector.
- Sits between the frame-buffer memories and the PE array.

Parameters:
- N, 16, block size in pixels; power of two, 4..16; NPE = N; LOGN = log2(N).
- DW, 8, pixel and distortion width; must match the PE accumulate width.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin a full search; sampled only in IDLE
- busy  out  1  high in PASS and DONE
- done  out  1  one-cycle pulse when results are valid
- r_addr  out  2*LOGN  reference block address, {row,col}
- r_en  out  1  reference read enable
- s1_addr  out  2*LOGN+1  left search half address, {row(LOGN+1),col(LOGN)}
- s2_addr  out  2*LOGN+1  right search half address, same format
- s_en  out  1  search memories read enable
- s1s2_mux  out  NPE  per-PE select; 1 selects s1
- new_dist  out  NPE  per-PE start-new-distortion strobe
- acc_bus  in  NPE*DW  PE accumulate outputs; PE k occupies [k*DW+DW-1:k*DW]
- best_dist  out  DW  minimum SAD found
- best_mv_x  out  LOGN  signed horizontal vector, -N/2..N/2-1
- best_mv_y  out  LOGN  signed vertical vector, -N/2..N/2-1

Behaviour:
- Memories are synchronous with 1-cycle read latency: an address issued at pc produces data at pc+1. The PE r input is chained one stage per PE.
- Reset values: state IDLE; busy=0, done=0, r_en=0, s_en=0; all addresses 0; s1s2_mux=0, new_dist=0; best_dist all ones; best_mv_x=0, best_mv_y=0.
- FSM IDLE -> PASS on start. In PASS, counter v (0..N-1) selects the vertical displacement and pass counter pc runs 0..N*N+NPE (273 cycles for N=16).
- At pc == N*N+NPE: if v == N-1, go to DONE; otherwise v++ and pc=0.
- DONE lasts one cycle with done=1, then returns to IDLE.
- start is ignored while busy.
- Issue window, pc 0..N*N+NPE-2, with c = pc:
  - s_en=1; s1_addr = {c/N + v, c mod N}; s2_addr = {c/N + v - 1, c mod N}. The s2 row wraps when c<N; that data is never selected.
  - r_en=1 and r_addr = c only while c < N*N; otherwise r_en=0 and r_addr holds.
- Registered (1-cycle-delayed) decode of c:
  - new_dist[k]=1 exactly when pc == k+1.
  - s1s2_mux[k] = ((c mod N) >= k).
  - Both are 0 outside the issue window.
- Sampling: PE k's final SAD is stable on acc_bus during pc == N*N+1+k and is sampled at that clock edge.
- Candidate for PE k: mv_x = k - N/2, mv_y = v - N/2.
- Compare rules:
  - The first candidate of a search (v=0, k=0) is loaded unconditionally.
  - After that, replace the held result only if the candidate SAD < best_dist (strict). Ties keep the earliest candidate in v-major, k-minor order.
- best_* update internally during the search but are guaranteed only from the done cycle. They hold until the next start.
- Latency: done is asserted exactly N*(N*N+NPE+1)+1 cycles after the start-sampling edge (4369 for N=16).
- reset_n asserted mid-search: immediate return to reset values, and no done pulse.

Optional Feature:
- Macro ME_EARLY_EXIT_EN.
- When defined: if best_dist == 0 at the end of a pass (pc == N*N+NPE), go directly to DONE without starting further passes. The reported vector is the first zero-SAD candidate.
- When undefined: all N passes always run.

Test Plan:
- Control timing, N=16, first pass: new_dist[3]=1 only at pc=4. At c=20 (pc=21), s1_addr={1,4}, s2_addr={0,4}, and s1s2_mux[4]=1, s1s2_mux[5]=0. r_en=0 from pc=256.
- Reference block equal to the search window at row 8, col 8, other pixels random -> best_dist=0, best_mv_x=0, best_mv_y=0, done at cycle 4369.
- Block placed at search offset row 6, col 11 -> best_mv_x=+3, best_mv_y=-2, best_dist=0.
- All pixels equal (all SAD=0) -> mv (-8,-8). Then an acc_bus override forcing every SAD to 0xFF -> mv (-8,-8), best_dist=0xFF.
- reset_n low at pc=100 of pass 5 -> all outputs at reset values, no done pulse. A subsequent start gives the correct result. start pulsed during busy -> no effect on v, pc or done timing.
- ME_EARLY_EXIT_EN defined, exact match at v=0 -> done after 1*273+1 cycles. Undefined -> 4369 cycles.
